// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8-bit UART transmitter with start/busy/clear handshake.
// One byte per request, optional even/odd parity, one or two stop bits.
// Every output comes straight from a flop, so ser_tx cannot glitch.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 4167,  // clock cycles per serial bit, 2..65535
    parameter int PARITY       = 0,     // 0 none, 1 even, 2 odd
    parameter int STOP_BITS    = 1      // 1 or 2
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       ser_tx,
    output logic       tx_busy,
    output logic       tx_clear_req
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic           HAS_PAR   = (PARITY != 0);
    localparam logic           ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // Registered state
    state_t        r_state;
    logic [CW-1:0] r_baud;    // cycle within current bit
    logic [2:0]    r_bit;     // data bit index, then stop bit index
    logic [7:0]    r_shift;   // bytes leave LSB first
    logic          r_par;     // parity bit computed at accept
    logic          r_armed;   // tx_start has been seen low since last accept
    logic          r_ser;
    logic          r_busy;
    logic          r_clr;

    // Next-state values
    state_t        w_state;
    logic [CW-1:0] w_baud;
    logic [2:0]    w_bit;
    logic [7:0]    w_shift;
    logic          w_par;
    logic          w_armed;
    logic          w_ser;
    logic          w_busy;
    logic          w_clr;
    logic          w_baud_done;

    assign ser_tx       = r_ser;
    assign tx_busy      = r_busy;
    assign tx_clear_req = r_clr;

    assign w_baud_done  = (r_baud == BAUD_LAST);

    // State and output registers; reset forces the line idle at once
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_armed <= 1'b0;
            r_ser   <= 1'b1;
            r_busy  <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_par   <= w_par;
            r_armed <= w_armed;
            r_ser   <= w_ser;
            r_busy  <= w_busy;
            r_clr   <= w_clr;
        end
    end

    // Next-state and next-output logic; ser_tx is computed one cycle ahead
    // so the flop presents each bit exactly on its first edge
    always_comb begin
        w_state = r_state;
        w_baud  = r_baud;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_par   = r_par;
        w_ser   = r_ser;
        w_busy  = r_busy;
        w_clr   = 1'b0;
        // Any low tx_start re-arms; a level held across frames or reset
        // therefore cannot launch a second frame.
        w_armed = r_armed | ~tx_start;

        unique case (r_state)
            S_IDLE: begin
                w_ser  = 1'b1;
                w_busy = 1'b0;
                w_baud = '0;
                w_bit  = '0;
                if (tx_start && r_armed) begin
                    w_shift = tx_data;
                    w_par   = ODD_PAR ? ~(^tx_data) : (^tx_data);
                    w_armed = 1'b0;
                    w_busy  = 1'b1;
                    w_ser   = 1'b0;
                    w_state = S_START;
                end
            end

            S_START: begin
                if (w_baud_done) begin
                    w_baud  = '0;
                    w_bit   = '0;
                    w_ser   = r_shift[0];
                    w_state = S_DATA;
                end else begin
                    w_baud = r_baud + CW'(1);
                end
            end

            S_DATA: begin
                if (w_baud_done) begin
                    w_baud = '0;
                    if (r_bit == 3'd7) begin
                        w_bit = '0;
                        if (HAS_PAR) begin
                            w_ser   = r_par;
                            w_state = S_PAR;
                        end else begin
                            w_ser   = 1'b1;
                            w_state = S_STOP;
                        end
                    end else begin
                        w_bit   = r_bit + 3'd1;
                        w_shift = {1'b0, r_shift[7:1]};
                        w_ser   = r_shift[1];
                    end
                end else begin
                    w_baud = r_baud + CW'(1);
                end
            end

            S_PAR: begin
                if (w_baud_done) begin
                    w_baud  = '0;
                    w_bit   = '0;
                    w_ser   = 1'b1;
                    w_state = S_STOP;
                end else begin
                    w_baud = r_baud + CW'(1);
                end
            end

            S_STOP: begin
                w_ser = 1'b1;
                if (w_baud_done) begin
                    w_baud = '0;
                    if (r_bit == STOP_LAST) begin
                        // Last cycle of the final stop bit: frame ends here
                        w_bit   = '0;
                        w_busy  = 1'b0;
                        w_clr   = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        w_bit = r_bit + 3'd1;
                    end
                end else begin
                    w_baud = r_baud + CW'(1);
                end
            end

            default: begin
                w_ser   = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four instances cover no/even/odd parity and two
// stop bits; a frame-level model is compared against every instance each
// cycle, and directed runs pin the model with hand-computed values.
module tb_uart_tx_frame;

    localparam int C  = 16;
    localparam int NI = 4;
    localparam int PAR_T [NI] = '{0, 1, 2, 0};
    localparam int STP_T [NI] = '{1, 1, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rstn;
    logic [NI-1:0]          st;
    logic [NI-1:0][7:0]     dat;
    wire  [NI-1:0]          ser;
    wire  [NI-1:0]          busy;
    wire  [NI-1:0]          clr;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            uart_tx_frame #(
                .CLKS_PER_BIT(C),
                .PARITY      (PAR_T[g]),
                .STOP_BITS   (STP_T[g])
            ) u_dut (
                .clock       (clk),
                .resetb      (rstn),
                .tx_start    (st[g]),
                .tx_data     (dat[g]),
                .ser_tx      (ser[g]),
                .tx_busy     (busy[g]),
                .tx_clear_req(clr[g])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    bit go = 1'b0;

    // Frame-level model: on accept, build the whole frame as a bit vector
    logic        m_armed [NI];
    logic        m_busy  [NI];
    logic        m_clr   [NI];
    int          m_t     [NI];
    int          m_len   [NI];
    logic [11:0] m_bits  [NI];

    // Model update at each edge (frame time advances, accept builds frame)
    always @(posedge clk or negedge rstn) begin
        logic        a, b, c;
        int          t, len, n;
        logic [11:0] bits;
        if (!rstn) begin
            for (int i = 0; i < NI; i++) begin
                m_armed[i] <= 1'b0;
                m_busy[i]  <= 1'b0;
                m_clr[i]   <= 1'b0;
                m_t[i]     <= 0;
                m_len[i]   <= 0;
                m_bits[i]  <= '1;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                a = m_armed[i]; b = m_busy[i]; c = 1'b0;
                t = m_t[i]; len = m_len[i]; bits = m_bits[i];
                if (b) begin
                    t = t + 1;
                    if (t == len * C) begin
                        b = 1'b0;
                        c = 1'b1;
                    end
                end else if (st[i] && a) begin
                    bits      = '1;
                    bits[0]   = 1'b0;
                    bits[8:1] = dat[i];
                    n = 9;
                    if (PAR_T[i] != 0) begin
                        bits[9] = (PAR_T[i] == 1) ? ^dat[i] : ~(^dat[i]);
                        n = 10;
                    end
                    len = n + STP_T[i];
                    t = 0;
                    b = 1'b1;
                    a = 1'b0;
                end
                if (!st[i]) a = 1'b1;
                m_armed[i] <= a;
                m_busy[i]  <= b;
                m_clr[i]   <= c;
                m_t[i]     <= t;
                m_len[i]   <= len;
                m_bits[i]  <= bits;
            end
        end
    end

    // Compare every instance against the model away from the active edge
    always @(negedge clk) begin
        logic es;
        if (go) begin
            for (int i = 0; i < NI; i++) begin
                es = m_busy[i] ? m_bits[i][m_t[i] / C] : 1'b1;
                checks = checks + 1;
                if ({ser[i], busy[i], clr[i]} !== {es, m_busy[i], m_clr[i]}) begin
                    errors = errors + 1;
                    $display("FAIL model[%0d] t=%0d ser/busy/clr got %b%b%b expected %b%b%b",
                             i, m_t[i], ser[i], busy[i], clr[i], es, m_busy[i], m_clr[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Request a frame on instance i and observe it for ncyc cycles,
    // sampling ser_tx mid-bit; optionally swap tx_data at cycle chg
    task automatic run(input int i, input logic [7:0] d, input int ncyc,
                       input int chg, input logic [7:0] d2, input bit drop,
                       output int nb, output int nc, output logic [11:0] b);
        int t;
        nb = 0; nc = 0; b = '1; t = 0;
        dat[i] = d;
        st[i]  = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == chg) dat[i] = d2;
            if (busy[i]) begin
                if ((t % C) == C / 2 && (t / C) < 12) b[t / C] = ser[i];
                t  = t + 1;
                nb = nb + 1;
            end
            if (clr[i]) begin
                nc = nc + 1;
                if (drop) st[i] = 1'b0;
            end
        end
    endtask

    initial begin
        int          nb, nc, cnt_b, cnt_c, t;
        logic [11:0] b;
        bit          seen;

        rstn = 1'b0;
        st   = '0;
        dat  = '0;
        repeat (3) @(negedge clk);
        chk("reset_ser",  32'(ser),  32'hF);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_clr",  32'(clr),  32'h0);
        rstn = 1'b1;
        go   = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5, no parity, one stop bit
        run(0, 8'hA5, 200, -1, 8'h00, 1'b1, nb, nc, b);
        chk("a5_bits",  32'(b[9:0]), 32'h34A);   // 0,1,0,1,0,0,1,0,1,1 LSB first
        chk("a5_busy",  32'(nb), 32'd160);
        chk("a5_clear", 32'(nc), 32'd1);

        // 0x03 even parity then odd parity
        run(1, 8'h03, 200, -1, 8'h00, 1'b1, nb, nc, b);
        chk("even_par",  32'(b[9]), 32'd0);
        chk("even_data", 32'(b[8:1]), 32'h03);
        chk("even_len",  32'(nb), 32'd176);
        run(2, 8'h03, 200, -1, 8'h00, 1'b1, nb, nc, b);
        chk("odd_par",   32'(b[9]), 32'd1);
        chk("odd_stop",  32'(b[10]), 32'd1);
        chk("odd_len",   32'(nb), 32'd176);

        // tx_start held high for 400 cycles, two stop bits: one frame only
        run(3, 8'h55, 400, -1, 8'h00, 1'b0, nb, nc, b);
        chk("held_busy",  32'(nb), 32'd176);
        chk("held_clear", 32'(nc), 32'd1);
        chk("held_data",  32'(b[8:1]), 32'h55);
        chk("held_stops", 32'(b[10:9]), 32'h3);
        st[3] = 1'b0;
        @(negedge clk);
        st[3] = 1'b1;
        @(negedge clk);
        chk("rearm_start", 32'(busy[3]), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (clr[3]) seen = 1'b1;
        end
        chk("rearm_end", 32'(seen), 32'd1);
        st[3] = 1'b0;
        @(negedge clk);

        // tx_data changed mid-frame must not affect the frame in flight
        run(0, 8'h11, 200, 40, 8'hEE, 1'b1, nb, nc, b);
        chk("datachg_data", 32'(b[8:1]), 32'h11);

        // Asynchronous reset at cycle 70 of a frame
        dat[0] = 8'h3C;
        st[0]  = 1'b1;
        t = 0;
        for (int c = 0; c < 100 && t < 70; c++) begin
            @(negedge clk);
            if (busy[0]) t = t + 1;
        end
        #2 rstn = 1'b0;
        #1;
        chk("async_ser",  32'(ser[0]),  32'd1);
        chk("async_busy", 32'(busy[0]), 32'd0);
        chk("async_clr",  32'(clr[0]),  32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cnt_b = 0; cnt_c = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busy[0]) cnt_b = cnt_b + 1;
            if (clr[0])  cnt_c = cnt_c + 1;
        end
        chk("post_rst_busy",  32'(cnt_b), 32'd0);
        chk("post_rst_clear", 32'(cnt_c), 32'd0);
        st[0] = 1'b0;
        @(negedge clk);
        run(0, 8'h3C, 200, -1, 8'h00, 1'b1, nb, nc, b);
        chk("post_rst_len",  32'(nb), 32'd160);
        chk("post_rst_data", 32'(b[8:1]), 32'h3C);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
